// File: rtl/modexp_engine_if.sv
// Request/result bundle for modexp_engine: operands and start in, result and
// busy/done/err status out.
interface modexp_engine_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, data, N, key,
        input  result, busy, done, err
    );

    modport slave (
        input  start, data, N, key,
        output result, busy, done, err
    );
endinterface

// File: rtl/modexp_engine.sv
// Constant-time modular exponentiation (data^key mod N), right-to-left
// square-and-multiply over a bit-serial interleaved shift-add modular multiplier.
module modexp_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    modexp_engine_if.slave  bus
);
    localparam int PW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_MUL,
        S_SQR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] step_res;
    logic             last_bit;

    // One multiplier step: P' = 2P + a*B, then at most two subtractions of N.
    // With P < N and B < N the sum stays below 3N, so two suffice.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] p,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [PW-1:0] s;
        logic [PW-1:0] nw;
        nw = {2'b00, n};
        s  = {1'b0, p, 1'b0} + (a_bit ? {2'b00, b} : '0);
        if (s >= nw) s = s - nw;
        if (s >= nw) s = s - nw;
        return s[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            key_q      <= '0;
            a_q        <= '0;
            p_q        <= '0;
            base_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            bit_cnt_q  <= '0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            key_q      <= key_d;
            a_q        <= a_d;
            p_q        <= p_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            bit_cnt_q  <= bit_cnt_d;
            step_cnt_q <= step_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        key_d      = key_q;
        a_d        = a_q;
        p_d        = p_q;
        base_d     = base_q;
        acc_d      = acc_q;
        result_d   = result_q;
        bit_cnt_d  = bit_cnt_q;
        step_cnt_d = step_cnt_q;
        err_d      = err_q;

        b_sel    = (state_q == S_REDUCE) ? WIDTH'(1) : base_q;
        step_res = mm_step(p_q, a_q[WIDTH-1], b_sel, n_q);
        last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    err_d      = 1'b0;
                    n_d        = bus.N;
                    key_d      = bus.key;
                    p_d        = '0;
                    bit_cnt_d  = '0;
                    step_cnt_d = '0;
                    if (bus.N == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = bus.data;
                        base_d  = '0;
                        acc_d   = (bus.N == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = S_REDUCE;
                    end
                end
            end
            S_REDUCE, S_MUL, S_SQR: begin
                p_d       = step_res;
                a_d       = a_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit) begin
                    p_d       = '0;
                    bit_cnt_d = '0;
                    if (state_q == S_REDUCE) begin
                        base_d  = step_res;
                        a_d     = acc_q;
                        state_d = S_MUL;
                    end else if (state_q == S_MUL) begin
                        // Product is always computed; only the commit depends on the key bit.
                        if (key_q[0]) acc_d = step_res;
                        key_d   = key_q >> 1;
                        a_d     = base_q;
                        state_d = S_SQR;
                    end else begin
                        base_d = step_res;
                        if (step_cnt_q == CNT_W'(WIDTH - 1)) begin
                            result_d = acc_q;
                            state_d  = S_DONE;
                        end else begin
                            step_cnt_d = step_cnt_q + CNT_W'(1);
                            a_d        = acc_q;
                            state_d    = S_MUL;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.done   = (state_q == S_DONE);
    assign bus.busy   = (state_q == S_REDUCE) || (state_q == S_MUL) || (state_q == S_SQR);
endmodule

// File: tb/tb_modexp_engine.sv
// Bench for modexp_engine: a 6-bit and a 16-bit instance driven from a vector
// table through a scoreboard queue, plus handshake and mid-run reset sequences.
module tb_modexp_engine;
    localparam int LAT6    = 6 + 2 * 6 * 6 + 1;
    localparam int LAT16   = 16 + 2 * 16 * 16 + 1;
    localparam int TIMEOUT = 700;

    logic clk;
    logic rst;

    modexp_engine_if #(.WIDTH(6))  if6 ();
    modexp_engine_if #(.WIDTH(16)) if16 ();

    modexp_engine #(.WIDTH(6))  dut6  (.clk(clk), .rst(rst), .bus(if6));
    modexp_engine #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w16;
        logic [15:0] d;
        logic [15:0] n;
        logic [15:0] k;
        logic [15:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic drive(input bit w16, input logic [15:0] d, input logic [15:0] n,
                         input logic [15:0] k, input logic st);
        if (w16) begin
            if16.data = d; if16.N = n; if16.key = k; if16.start = st;
        end else begin
            if6.data = d[5:0]; if6.N = n[5:0]; if6.key = k[5:0]; if6.start = st;
        end
    endtask

    task automatic set_start(input bit w16, input logic st);
        if (w16) if16.start = st;
        else     if6.start  = st;
    endtask

    function automatic logic get_done(input bit w16);
        return w16 ? if16.done : if6.done;
    endfunction

    function automatic logic get_busy(input bit w16);
        return w16 ? if16.busy : if6.busy;
    endfunction

    function automatic logic get_err(input bit w16);
        return w16 ? if16.err : if6.err;
    endfunction

    function automatic logic [15:0] get_res(input bit w16);
        return w16 ? if16.result : {10'b0, if6.result};
    endfunction

    // Expected record must already be on the scoreboard; it is popped at done.
    task automatic run_job(input string tag, input bit w16, input logic [15:0] d,
                           input logic [15:0] n, input logic [15:0] k, input bit disturb);
        int   cyc;
        bit   got;
        bit   busy_ok;
        int   lat_want;
        exp_t e;
        @(negedge clk);
        drive(w16, d, n, k, 1'b1);
        lat_want = sb[0].lat;
        cyc = 0; got = 0; busy_ok = 1;
        while (!got && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) set_start(w16, 1'b0);
            if (disturb && cyc == 10)
                drive(w16, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            if (disturb && cyc == 11) set_start(w16, 1'b0);
            if (get_busy(w16) !== (cyc < lat_want)) busy_ok = 0;
            if (get_done(w16) === 1'b1) got = 1;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            check({tag, "_result"}, 32'(get_res(w16)), 32'(e.res));
            check({tag, "_err"}, 32'(get_err(w16)), 32'(e.err));
            check({tag, "_busy"}, 32'(busy_ok), 32'd1);
            @(negedge clk);
            check({tag, "_one_pulse"}, 32'(get_done(w16)), 32'd0);
            check({tag, "_held"}, 32'(get_res(w16)), 32'(e.res));
        end
    endtask

    initial begin
        int   saw;
        exp_t e;
        total = 0;
        bad   = 0;
        tbl = '{
            '{0,     43,    20,    10,     9, 0},
            '{0,      5,    20,     0,     1, 0},
            '{0,     37,     1,    45,     0, 0},
            '{0,     63,    63,    63,     0, 0},
            '{0,     62,    63,    63,    62, 0},
            '{0,      0,    20,     5,     0, 0},
            '{0,      2,    63,    63,     8, 0},
            '{0,     63,    62,    63,     1, 0},
            '{0,     63,     0,    21,     0, 1},
            '{0,     43,    20,    10,     9, 0},
            '{1,     65,  3233,    17,  2790, 0},
            '{1,   2790,  3233,  2753,    65, 0},
            '{1,  65535, 65535, 65535,     0, 0},
            '{1,  65534, 65535, 65535, 65534, 0},
            '{1,      2, 65535,    16,     1, 0}
        };

        rst = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_result6", 32'(if6.result), 32'd0);
        check("reset_busy6", 32'(if6.busy), 32'd0);
        check("reset_done6", 32'(if6.done), 32'd0);
        check("reset_err6", 32'(if6.err), 32'd0);
        check("reset_result16", 32'(if16.result), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            e.res = tbl[i].res;
            e.err = tbl[i].err;
            e.lat = tbl[i].err ? 1 : (tbl[i].w16 ? LAT16 : LAT6);
            sb.push_back(e);
            run_job($sformatf("vec%0d", i), tbl[i].w16, tbl[i].d, tbl[i].n, tbl[i].k, 1'b0);
        end

        // Operands toggled and start pulsed while busy must not disturb the job.
        e.res = 9; e.err = 0; e.lat = LAT6;
        sb.push_back(e);
        run_job("busy_ignore", 0, 43, 20, 10, 1'b1);
        saw = 0;
        repeat (100) begin
            @(negedge clk);
            if (if6.done === 1'b1) saw = 1;
        end
        check("busy_ignore_no_second_done", 32'(saw), 32'd0);

        // Reset 30 cycles into a job: outputs clear at once and no done follows.
        @(negedge clk);
        drive(0, 43, 20, 10, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (29) @(negedge clk);
        check("midrun_busy_before_rst", 32'(if6.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun_rst_result", 32'(if6.result), 32'd0);
        check("midrun_rst_busy", 32'(if6.busy), 32'd0);
        check("midrun_rst_done", 32'(if6.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (100) begin
            @(negedge clk);
            if (if6.done === 1'b1 || if6.busy === 1'b1) saw = 1;
        end
        check("midrun_no_done_after_rst", 32'(saw), 32'd0);
        e.res = 9; e.err = 0; e.lat = LAT6;
        sb.push_back(e);
        run_job("after_rst", 0, 43, 20, 10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modexp_engine.md
Name: modexp_engine

Overview:
- Parametrised successor to the fixed 6-bit RSA top: computes result = data^key mod N for WIDTH-bit operands.
- Right-to-left binary square-and-multiply built on an interleaved shift-add modular multiplier, with one bit processed per clock.
- Constant-time: latency depends only on WIDTH, never on key or data.
- Adds reset, a busy/done handshake, and N==0 error reporting.

Parameters:
- WIDTH, 16, operand width in bits for data, N, key and result (WIDTH >= 2).
- CNT_W, $clog2(WIDTH), width of the bit/step counters (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only while busy=0
- data  in  WIDTH  message/ciphertext (may be >= N)
- N  in  WIDTH  modulus
- key  in  WIDTH  exponent
- result  out  WIDTH  data^key mod N; registered, held until next completion
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  set with done when N==0; held until next accepted start

Behaviour:
- Reset (async, any state): FSM to IDLE; result=0, busy=0, done=0, err=0; all internal registers cleared.
- Start acceptance: start=1 while in IDLE. The edge captures data, N and key into internal registers, so later input changes have no effect. err is cleared. start while busy is ignored.
- States: IDLE -> REDUCE -> (MUL -> SQR) x WIDTH -> DONE -> IDLE.
  - N==0 takes IDLE -> DONE directly: err=1, result=0.
- Modular multiply step, used by every phase. P = 2P + a_i*B, then subtract N while P >= N (at most 2 subtractions). Bits a_i are taken MSB first, one per cycle, over WIDTH cycles. P and the adder are WIDTH+2 bits wide, and the invariant P < N holds after every step.
- REDUCE (WIDTH cycles): base = data*1 mod N, with A=data and B=1. In parallel, acc = 1 mod N (acc=0 when N==1).
- Exponent loop: for key bits i = 0..WIDTH-1, LSB first.
  - MUL (WIDTH cycles): tmp = acc*base mod N. The result is committed to acc only if key[i]=1; it is always computed, for constant time.
  - SQR (WIDTH cycles): base = base*base mod N. This also runs after the final bit.
- DONE (1 cycle): result <= acc, done=1, busy=0; then IDLE.
- Latency: with the start edge counted as cycle 0, done is high during cycle WIDTH + 2*WIDTH*WIDTH + 1. That is 79 cycles for WIDTH=6 and 529 for WIDTH=16.
- The N==0 path has done high in cycle 1.
- A start asserted in the same cycle done is high is ignored, because the FSM is not yet in IDLE. A start is accepted from the next cycle on.
- Boundaries:
  - key=0 -> result = 1 mod N.
  - N=1 -> result=0.
  - data=0 with key!=0 -> result=0.
  - data >= N is handled by REDUCE.
  - Full-scale operands (all ones) must not overflow the WIDTH+2-bit datapath.
- Reset asserted mid-operation aborts the computation with no done pulse. After release the block is idle and accepts a new start.

Test Plan:
- WIDTH=6, data=43, N=20, key=10, 1-cycle start -> done exactly 79 cycles later, result=9, err=0; busy high for cycles 1..78.
- WIDTH=16, data=65, N=3233, key=17 -> result=2790. Then start with data=2790, key=2753 -> result=65. Both runs take 529 cycles.
- WIDTH=6, N=0, data and key arbitrary -> done in cycle 1, err=1, result=0. A following valid start clears err.
- WIDTH=6 corner cases:
  - key=0, N=20 -> result=1.
  - N=1 -> result=0.
  - data=63, key=63, N=63 -> result=0.
  - data=62, key=63, N=63 -> result=62.
- WIDTH=6 handshake: toggle data, N and key and pulse start while busy -> result still 9 for the original 43/20/10 job; no second done.
- Reset mid-run: assert rst 30 cycles into a job -> outputs zero immediately, no done. After release, start a new job -> correct result at nominal latency.
